// File: rtl/cpu_control_unit_if.sv
// Control/status bundle between the CPU control unit and the accumulator datapath.
//   master (control unit): drives the load strobes, mux selects, ALU opcode and
//                          memory write enable; reads back IR contents and AC==0.
//   slave  (datapath)    : the opposite directions.
// Signals:
//   ir_in[15:0]  current IR contents            ac_zero   AC == 0
//   pc_inc       PC <= PC + 1                   pc_load   PC <= {4'b0, ir_in[11:0]}
//   mar_load     MAR load                       mar_sel   0 = PC, 1 = ir_in[11:0]
//   ir_load      IR <= memory data_out          mbr_load  MBR <= memory data_out
//   ac_load      AC load                        ac_sel    0 = ALU result, 1 = MBR
//   alu_op[3:0]  ALU opcode (AC op MBR)         mem_we    mem[MAR] <= AC
interface cpu_control_unit_if;
    logic [15:0] ir_in;
    logic        ac_zero;
    logic        pc_inc;
    logic        pc_load;
    logic        mar_load;
    logic        mar_sel;
    logic        ir_load;
    logic        mbr_load;
    logic        ac_load;
    logic        ac_sel;
    logic [3:0]  alu_op;
    logic        mem_we;

    modport master (
        input  ir_in, ac_zero,
        output pc_inc, pc_load, mar_load, mar_sel, ir_load, mbr_load,
               ac_load, ac_sel, alu_op, mem_we
    );

    modport slave (
        output ir_in, ac_zero,
        input  pc_inc, pc_load, mar_load, mar_sel, ir_load, mbr_load,
               ac_load, ac_sel, alu_op, mem_we
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   start        level; begins/resumes fetch from IDLE or HALT
//   dp           datapath control bundle (master side)
//   halted       high while in HALT
//   illegal      sticky; last halt was caused by an undefined opcode
//   instr_count  retired-instruction counter (wraps)
//   state_dbg    current state encoding
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | after reset, waiting for start (or AUTO_START)
// F1    | MAR <= PC
// F2    | memory samples MAR
// F3    | IR <= memory, PC <= PC + 1
// DEC   | decode; set up operand address or finish short ops
// RD1   | memory samples operand address
// RD2   | MBR <= memory
// EXE   | AC <= MBR or ALU(AC, MBR)
// ST    | mem[MAR] <= AC
// HALT  | stopped; start resumes fetch at current PC
module cpu_control_unit #(
    parameter bit AUTO_START = 1'b0,
    parameter int COUNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    cpu_control_unit_if.master     dp,
    output logic                   halted,
    output logic                   illegal,
    output logic [COUNT_W-1:0]     instr_count,
    output logic [3:0]             state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F1   = 4'd1,
        S_F2   = 4'd2,
        S_F3   = 4'd3,
        S_DEC  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_EXE  = 4'd7,
        S_ST   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    state_t     state, state_nxt;
    logic       retire;
    logic       set_illegal;
    logic       clr_illegal;
    logic [3:0] opcode;

    assign opcode    = dp.ir_in[15:12];
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (set_illegal)
                illegal <= 1'b1;
            else if (clr_illegal)
                illegal <= 1'b0;
            if (retire)
                instr_count <= instr_count + COUNT_W'(1);
        end
    end

    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        set_illegal = 1'b0;
        clr_illegal = 1'b0;
        halted      = 1'b0;
        dp.pc_inc   = 1'b0;
        dp.pc_load  = 1'b0;
        dp.mar_load = 1'b0;
        dp.mar_sel  = 1'b0;
        dp.ir_load  = 1'b0;
        dp.mbr_load = 1'b0;
        dp.ac_load  = 1'b0;
        dp.ac_sel   = 1'b0;
        dp.alu_op   = 4'b0000;
        dp.mem_we   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start || AUTO_START)
                    state_nxt = S_F1;
            end
            S_F1: begin
                dp.mar_load = 1'b1;
                state_nxt   = S_F2;
            end
            S_F2: begin
                state_nxt = S_F3;
            end
            S_F3: begin
                dp.ir_load = 1'b1;
                dp.pc_inc  = 1'b1;
                state_nxt  = S_DEC;
            end
            S_DEC: begin
                case (opcode)
                    4'h0: begin
                        retire    = 1'b1;
                        state_nxt = S_F1;
                    end
                    4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        dp.mar_load = 1'b1;
                        dp.mar_sel  = 1'b1;
                        state_nxt   = S_RD1;
                    end
                    4'h2: begin
                        dp.mar_load = 1'b1;
                        dp.mar_sel  = 1'b1;
                        state_nxt   = S_ST;
                    end
                    4'h8, 4'h9: begin
                        state_nxt = S_EXE;
                    end
                    4'hA: begin
                        dp.pc_load = 1'b1;
                        retire     = 1'b1;
                        state_nxt  = S_F1;
                    end
                    4'hB: begin
                        dp.pc_load = dp.ac_zero;
                        retire     = 1'b1;
                        state_nxt  = S_F1;
                    end
                    4'hF: begin
                        retire    = 1'b1;
                        state_nxt = S_HALT;
                    end
                    default: begin
                        // C/D/E are undefined: stop without retiring
                        set_illegal = 1'b1;
                        state_nxt   = S_HALT;
                    end
                endcase
            end
            S_RD1: begin
                state_nxt = S_RD2;
            end
            S_RD2: begin
                dp.mbr_load = 1'b1;
                state_nxt   = S_EXE;
            end
            S_EXE: begin
                dp.ac_load = 1'b1;
                retire     = 1'b1;
                state_nxt  = S_F1;
                // IR is only reloaded in F3, so ir_in still holds this opcode
                case (opcode)
                    4'h1:    dp.ac_sel = 1'b1;
                    4'h3:    dp.alu_op = 4'b0000;
                    4'h4:    dp.alu_op = 4'b0001;
                    4'h5:    dp.alu_op = 4'b1000;
                    4'h6:    dp.alu_op = 4'b1001;
                    4'h7:    dp.alu_op = 4'b1010;
                    4'h8:    dp.alu_op = 4'b0100;
                    4'h9:    dp.alu_op = 4'b0101;
                    default: dp.alu_op = 4'b0000;
                endcase
            end
            S_ST: begin
                dp.mem_we = 1'b1;
                retire    = 1'b1;
                state_nxt = S_F1;
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    clr_illegal = 1'b1;
                    state_nxt   = S_F1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
